// File: rtl/bcd_seg_display.sv
// Sequential double-dabble binary-to-BCD converter with registered active-low 7-segment outputs.
// Optional macro BCD_SEG_BLANK_LEADING_EN blanks leading zero digits on the display.
module bcd_seg_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Overflow can only happen when the largest input exceeds the largest displayable value.
  localparam logic OVF_POSSIBLE = (((64'd1 << WIDTH) - 64'd1) > (pow10(DIGITS) - 64'd1));

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  sh_r;
  logic [BW-1:0]     acc_r;
  logic [CW-1:0]     cnt_r;
  logic              ovf_r;

  logic [BW-1:0]     acc_adj_s;
  logic [BW+WIDTH:0] shifted_s;
  logic [SW-1:0]     seg_next_s;
`ifdef BCD_SEG_BLANK_LEADING_EN
  logic              lead_s;
`endif

  // Add-3 correction on every accumulator digit that would reach 10 or more after doubling.
  always_comb begin
    acc_adj_s = acc_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) begin
        acc_adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      end else begin
        acc_adj_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
  end

  // Top bit is the digit carried out of the accumulator; then new accumulator; then shift register.
  assign shifted_s = {acc_adj_s, sh_r, 1'b0};

  // Display encoding of the finished accumulator, scanned from the most significant digit down.
  always_comb begin
    seg_next_s = '0;
`ifdef BCD_SEG_BLANK_LEADING_EN
    lead_s = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_r) begin
        seg_next_s[7*i +: 7] = 7'b0111111;
`ifdef BCD_SEG_BLANK_LEADING_EN
      end else if (lead_s && (i > 0) && (acc_r[4*i +: 4] == 4'd0)) begin
        seg_next_s[7*i +: 7] = 7'b1111111;
`endif
      end else begin
        seg_next_s[7*i +: 7] = seg_of(acc_r[4*i +: 4]);
      end
`ifdef BCD_SEG_BLANK_LEADING_EN
      if (acc_r[4*i +: 4] != 4'd0) begin
        lead_s = 1'b0;
      end else begin
        lead_s = lead_s;
      end
`endif
    end
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sh_r     <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      seg      <= {DIGITS{7'b1000000}};
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_r    <= data;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_INIT;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          done  <= 1'b0;
          acc_r <= shifted_s[BW+WIDTH-1:WIDTH];
          sh_r  <= shifted_s[WIDTH-1:0];
          ovf_r <= ovf_r | (shifted_s[BW+WIDTH] & OVF_POSSIBLE);
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          done     <= 1'b1;
          bcd      <= acc_r;
          seg      <= seg_next_s;
          overflow <= ovf_r;
          // A start here chains straight into the next conversion.
          if (start) begin
            sh_r    <= data;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_INIT;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display across four WIDTH/DIGITS configurations.
module tb_bcd_seg_display;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_a, start_b, start_c, start_d;
  logic [7:0]  data_a, data_b;
  logic [15:0] data_c, data_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
  logic [15:0] bcd_d;
  logic [20:0] seg_a;
  logic [13:0] seg_b;
  logic [34:0] seg_c;
  logic [27:0] seg_d;

  always #5 clk = ~clk;

  bcd_seg_display #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data(data_a), .busy(busy_a),
    .done(done_a), .bcd(bcd_a), .seg(seg_a), .overflow(ovf_a));
  bcd_seg_display #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data(data_b), .busy(busy_b),
    .done(done_b), .bcd(bcd_b), .seg(seg_b), .overflow(ovf_b));
  bcd_seg_display #(.WIDTH(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .data(data_c), .busy(busy_c),
    .done(done_c), .bcd(bcd_c), .seg(seg_c), .overflow(ovf_c));
  bcd_seg_display #(.WIDTH(16), .DIGITS(4)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .data(data_d), .busy(busy_d),
    .done(done_d), .bcd(bcd_d), .seg(seg_d), .overflow(ovf_d));

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic        obs_busy, obs_done, obs_ovf;
  logic [39:0] obs_bcd;
  logic [69:0] obs_seg;

  logic [39:0] q_bcd[$];
  logic [69:0] q_seg[$];
  logic        q_ovf[$];

  // Route the outputs of the currently selected instance to common observation signals.
  always_comb begin
    obs_busy = 1'b0; obs_done = 1'b0; obs_ovf = 1'b0; obs_bcd = '0; obs_seg = '0;
    case (sel)
      0: begin obs_busy = busy_a; obs_done = done_a; obs_ovf = ovf_a; obs_bcd = 40'(bcd_a); obs_seg = 70'(seg_a); end
      1: begin obs_busy = busy_b; obs_done = done_b; obs_ovf = ovf_b; obs_bcd = 40'(bcd_b); obs_seg = 70'(seg_b); end
      2: begin obs_busy = busy_c; obs_done = done_c; obs_ovf = ovf_c; obs_bcd = 40'(bcd_c); obs_seg = 70'(seg_c); end
      3: begin obs_busy = busy_d; obs_done = done_d; obs_ovf = ovf_d; obs_bcd = 40'(bcd_d); obs_seg = 70'(seg_d); end
      default: begin obs_busy = 1'b0; end
    endcase
  end

  function automatic int digits_of(input int s);
    case (s)
      0: return 3;
      1: return 2;
      2: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic int width_of(input int s);
    return (s < 2) ? 8 : 16;
  endfunction

  function automatic longint unsigned p10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] glyph(input longint unsigned d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [39:0] model_bcd(input longint unsigned v, input int digits);
    logic [39:0] r = '0;
    for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [69:0] model_seg(input longint unsigned v, input int digits);
    logic [69:0] r = '0;
    longint unsigned t = v % p10(digits);
    bit ovf = (v >= p10(digits));
    bit blank_en = 1'b0;
`ifdef BCD_SEG_BLANK_LEADING_EN
    blank_en = 1'b1;
`endif
    for (int i = 0; i < digits; i++) begin
      if (ovf) r[7*i +: 7] = 7'b0111111;
      else if (blank_en && i > 0 && t < p10(i)) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = glyph((t / p10(i)) % 10);
    end
    return r;
  endfunction

  task automatic drive(input int s, input logic st, input logic [15:0] v);
    case (s)
      0: begin start_a = st; data_a = v[7:0]; end
      1: begin start_b = st; data_b = v[7:0]; end
      2: begin start_c = st; data_c = v; end
      default: begin start_d = st; data_d = v; end
    endcase
  endtask

  task automatic kick(input int s, input int unsigned v, input bit push);
    if (push) begin
      q_bcd.push_back(model_bcd(v, digits_of(s)));
      q_seg.push_back(model_seg(v, digits_of(s)));
      q_ovf.push_back(v >= p10(digits_of(s)));
    end
    @(negedge clk);
    sel = s;
    drive(s, 1'b1, v[15:0]);
  endtask

  // Waits for done on the selected instance; scrambles data while busy unless start is held.
  task automatic wait_done(input bit hold, output int cyc, output int busy_cyc, output bit tout);
    cyc = 0; busy_cyc = 0; tout = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!hold) drive(sel, 1'b0, 16'($urandom));
      if (obs_done) break;
      if (obs_busy) busy_cyc++;
      if (cyc >= 60) begin tout = 1'b1; break; end
    end
  endtask

  task automatic sb_compare(input string name);
    logic [39:0] eb; logic [69:0] es; logic eo;
    if (q_bcd.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard: done with no expected entry", name);
    end else begin
      eb = q_bcd.pop_front(); es = q_seg.pop_front(); eo = q_ovf.pop_front();
      checks++;
      if (obs_bcd !== eb) begin failures++; $display("FAIL %s bcd: got %h expected %h", name, obs_bcd, eb); end
      checks++;
      if (obs_seg !== es) begin failures++; $display("FAIL %s seg: got %b expected %b", name, obs_seg, es); end
      checks++;
      if (obs_ovf !== eo) begin failures++; $display("FAIL %s overflow: got %b expected %b", name, obs_ovf, eo); end
    end
  endtask

  task automatic convert(input string name, input int s, input int unsigned v);
    int cyc, bc; bit tout;
    kick(s, v, 1'b1);
    wait_done(1'b0, cyc, bc, tout);
    checks++;
    if (tout || cyc != width_of(s) + 2 || bc != width_of(s) + 1) begin
      failures++;
      $display("FAIL %s latency: got done at %0d busy %0d timeout %0b expected %0d busy %0d",
               name, cyc, bc, tout, width_of(s) + 2, width_of(s) + 1);
    end
    sb_compare(name);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_ovf !== 1'b0 || obs_bcd !== 40'd0) begin
        failures++;
        $display("FAIL reset ctl[%0d]: got busy %b done %b ovf %b bcd %h expected 0 0 0 0",
                 s, obs_busy, obs_done, obs_ovf, obs_bcd);
      end
      checks++;
      if (obs_seg !== model_seg(0, digits_of(s)) && obs_seg !== 70'({10{7'b1000000}} & ((70'd1 << (7*digits_of(s))) - 70'd1))) begin
        failures++;
        $display("FAIL reset seg[%0d]: got %b expected all zero glyphs", s, obs_seg);
      end
    end
  endtask

  task automatic test_max_and_hold();
    logic [39:0] held;
    convert("max255", 0, 255);
    held = obs_bcd;
    @(negedge clk);
    checks++;
    if (obs_done !== 1'b0) begin failures++; $display("FAIL done_pulse: got %b expected 0", obs_done); end
    repeat (5) @(negedge clk);
    checks++;
    if (obs_bcd !== 40'h255 || held !== 40'h255) begin
      failures++; $display("FAIL hold: got %h expected %h", obs_bcd, 40'h255);
    end
  endtask

  task automatic test_overflow();
    convert("ovf100", 1, 100);
    convert("fit99", 1, 99);
  endtask

  task automatic test_back_to_back();
    int cyc, bc; bit tout;
    kick(0, 123, 1'b1);
    q_bcd.push_back(model_bcd(123, 3)); q_seg.push_back(model_seg(123, 3)); q_ovf.push_back(1'b0);
    wait_done(1'b1, cyc, bc, tout);
    checks++;
    if (tout || cyc != 10) begin failures++; $display("FAIL b2b first: got done at %0d expected 10", cyc); end
    sb_compare("b2b_first");
    wait_done(1'b0, cyc, bc, tout);
    checks++;
    if (tout || cyc != 9) begin failures++; $display("FAIL b2b second: got done at %0d expected 9", cyc); end
    sb_compare("b2b_second");
  endtask

  task automatic test_reset_abort();
    bit seen_done = 1'b0;
    kick(0, 200, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 16'd0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_busy !== 1'b0 || obs_bcd !== 40'd0 || obs_done !== 1'b0) begin
      failures++; $display("FAIL abort: got busy %b bcd %h done %b expected 0 000 0", obs_busy, obs_bcd, obs_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (obs_done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin failures++; $display("FAIL abort_no_done: got done 1 expected 0"); end
    convert("after_reset42", 0, 42);
  endtask

  task automatic test_wide();
    convert("w16d5_65535", 2, 65535);
    convert("w16d4_65535", 3, 65535);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) convert("rand8", 0, $urandom_range(255));
    for (int i = 0; i < 3; i++) convert("rand16", 3, $urandom_range(65535));
  endtask

  initial begin
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    data_a = 8'd0; data_b = 8'd0; data_c = 16'd0; data_d = 16'd0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_max_and_hold();
    convert("zero", 0, 0);
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
